// File: rtl/parity_arbiter.sv
// parity_arbiter: four requesters share one parity-check datapath.
// A round-robin arbiter picks a requester in IDLE and latches its word, parity bit and mode.
// CHECK computes the result and RESP presents it with a one-cycle done pulse.
// Failed checks feed a saturating error counter.
module parity_arbiter #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] data_in,
    input  logic [NREQ-1:0]       parity_in,
    input  logic                  odd_mode,
    input  logic                  clr_cnt,
    output logic                  busy,
    output logic [NREQ-1:0]       gnt,
    output logic [1:0]            gnt_id,
    output logic                  done,
    output logic                  parity_ok,
    output logic [7:0]            err_cnt
);

    typedef enum logic [1:0] {StIdle, StCheck, StResp} state_e;

    state_e            state_q, state_d;
    logic [1:0]        last_q;      // round-robin pointer: last served requester
    logic [1:0]        gnt_id_q;
    logic [WIDTH-1:0]  word_q;
    logic              par_q;
    logic              odd_q;
    logic              parity_ok_q;
    logic [7:0]        err_cnt_q;

    logic              sel_found;
    logic [1:0]        sel_id;
    logic [1:0]        idx;

    // Round-robin search starting one past the last served requester.
    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        idx       = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = last_q + 2'(i);
            if (!sel_found && req[idx]) begin
                sel_found = 1'b1;
                sel_id    = idx;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one check takes exactly three cycles once started.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (sel_found) state_d = StCheck;
            StCheck: state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output decode from the current state and latched grant.
    always_comb begin
        busy = (state_q != StIdle);
        done = (state_q == StResp);
        gnt  = '0;
        if (busy) begin
            gnt[gnt_id_q] = 1'b1;
        end
    end

    // Grant capture, parity evaluation and error counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q      <= 2'd3;        // requester 0 wins the first search
            gnt_id_q    <= '0;
            word_q      <= '0;
            par_q       <= 1'b0;
            odd_q       <= 1'b0;
            parity_ok_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            if (state_q == StIdle && sel_found) begin
                word_q   <= data_in[sel_id*WIDTH +: WIDTH];
                par_q    <= parity_in[sel_id];
                odd_q    <= odd_mode;
                gnt_id_q <= sel_id;
                last_q   <= sel_id;
            end
            if (state_q == StCheck) begin
                parity_ok_q <= ~((^word_q) ^ par_q ^ odd_q);
            end
            // Clear has priority over a coincident increment.
            if (clr_cnt) begin
                err_cnt_q <= '0;
            end else if (state_q == StResp && !parity_ok_q && err_cnt_q != 8'hFF) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    assign gnt_id    = gnt_id_q;
    assign parity_ok = parity_ok_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_parity_arbiter.sv
// tb_parity_arbiter: directed scenarios with hand-computed expectations.
module tb_parity_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data_in;
    logic [3:0]  parity_in;
    logic        odd_mode;
    logic        clr_cnt;
    logic        busy;
    logic [3:0]  gnt;
    logic [1:0]  gnt_id;
    logic        done;
    logic        parity_ok;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;

    parity_arbiter #(.WIDTH(8), .NREQ(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .data_in   (data_in),
        .parity_in (parity_in),
        .odd_mode  (odd_mode),
        .clr_cnt   (clr_cnt),
        .busy      (busy),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .done      (done),
        .parity_ok (parity_ok),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, gnt, gnt_id, done, parity_ok, err_cnt} !== 17'd0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b gnt=%b id=%0d done=%b ok=%b cnt=%0d, want all 0",
                     busy, gnt, gnt_id, done, parity_ok, err_cnt);
        end
        step();
        rst = 1'b0;
    endtask

    task automatic test_basic();
        req = 4'b0001; data_in = 32'h0000_0001; parity_in = 4'b0001; odd_mode = 1'b0;
        step();
        checks++;
        if (gnt !== 4'b0001 || gnt_id !== 2'd0 || busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL basic_grant: got gnt=%b id=%0d busy=%b done=%b, want 0001 0 1 0",
                     gnt, gnt_id, busy, done);
        end
        // Inputs changing after the grant must not disturb the in-flight check.
        req = 4'b0000; data_in = 32'h0000_0000; parity_in = 4'b0000; odd_mode = 1'b1;
        step();
        checks++;
        if (done !== 1'b1 || parity_ok !== 1'b1 || gnt !== 4'b0001) begin
            errors++;
            $display("FAIL basic_done: got done=%b ok=%b gnt=%b, want 1 1 0001", done, parity_ok, gnt);
        end
        step();
        checks++;
        if (done !== 1'b0 || gnt !== 4'b0000 || busy !== 1'b0 || gnt_id !== 2'd0
            || parity_ok !== 1'b1 || err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL basic_after: got done=%b gnt=%b busy=%b id=%0d ok=%b cnt=%0d, want 0 0000 0 0 1 0",
                     done, gnt, busy, gnt_id, parity_ok, err_cnt);
        end
    endtask

    task automatic test_parity_modes();
        logic [7:0] words [4] = '{8'hF0, 8'hF0, 8'h00, 8'h01};
        logic       pars  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic       odds  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic       exp_ok[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [7:0] exp_cnt[4] = '{8'd1, 8'd1, 8'd1, 8'd2};
        for (int i = 0; i < 4; i++) begin
            req = 4'b0001; data_in = {24'h0, words[i]}; parity_in = {3'b0, pars[i]};
            odd_mode = odds[i];
            step();
            req = 4'b0000;
            step();
            checks++;
            if (done !== 1'b1 || parity_ok !== exp_ok[i]) begin
                errors++;
                $display("FAIL parity_vec%0d: got done=%b ok=%b, want 1 %b", i, done, parity_ok, exp_ok[i]);
            end
            step();
            checks++;
            if (err_cnt !== exp_cnt[i]) begin
                errors++;
                $display("FAIL errcnt_vec%0d: got %0d, want %0d", i, err_cnt, exp_cnt[i]);
            end
        end
        odd_mode = 1'b0;
    endtask

    task automatic test_round_robin();
        logic exp_ok[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        do_reset();
        // words 01/03/07/FF with parity 1/1/1/0: only requester 1 fails in even mode
        data_in = 32'hFF07_0301; parity_in = 4'b0111; odd_mode = 1'b0; req = 4'b1111;
        for (int t = 0; t < 12; t++) begin
            step();
            checks++;
            if (gnt_id !== 2'(t % 4) || gnt !== (4'b0001 << (t % 4))) begin
                errors++;
                $display("FAIL rr_grant%0d: got id=%0d gnt=%b, want %0d", t, gnt_id, gnt, t % 4);
            end
            step();
            checks++;
            if (done !== 1'b1 || parity_ok !== exp_ok[t % 4]) begin
                errors++;
                $display("FAIL rr_result%0d: got done=%b ok=%b, want 1 %b", t, done, parity_ok, exp_ok[t % 4]);
            end
            step();
        end
        checks++;
        if (err_cnt !== 8'd3) begin
            errors++;
            $display("FAIL rr_errcnt: got %0d, want 3", err_cnt);
        end
    endtask

    task automatic test_alternate();
        logic [1:0] exp_id[4] = '{2'd0, 2'd2, 2'd0, 2'd2};
        req = 4'b0101;
        for (int t = 0; t < 4; t++) begin
            step();
            checks++;
            if (gnt_id !== exp_id[t] || gnt[1] !== 1'b0) begin
                errors++;
                $display("FAIL alt_grant%0d: got id=%0d gnt=%b, want %0d", t, gnt_id, gnt, exp_id[t]);
            end
            step();
            step();
        end
        req = 4'b0000;
    endtask

    task automatic test_saturation();
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        checks++;
        if (err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL clr_idle: got %0d, want 0", err_cnt);
        end
        req = 4'b0001; data_in = 32'h0000_0001; parity_in = 4'b0000; odd_mode = 1'b0;
        for (int t = 1; t <= 257; t++) begin
            step();
            step();
            step();
            if (t == 255 || t == 256 || t == 257) begin
                checks++;
                if (err_cnt !== 8'hFF) begin
                    errors++;
                    $display("FAIL sat_after%0d: got %0d, want 255", t, err_cnt);
                end
            end
        end
        // Clear lands on the same edge as a failing increment.
        step();
        step();
        checks++;
        if (done !== 1'b1 || parity_ok !== 1'b0) begin
            errors++;
            $display("FAIL clr_resp: got done=%b ok=%b, want 1 0", done, parity_ok);
        end
        clr_cnt = 1'b1;
        req = 4'b0000;
        step();
        clr_cnt = 1'b0;
        checks++;
        if (err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL clr_wins: got %0d, want 0", err_cnt);
        end
    endtask

    task automatic test_reset_mid();
        req = 4'b0010; data_in = 32'h0000_0100; parity_in = 4'b0000; odd_mode = 1'b0;
        step();
        checks++;
        if (busy !== 1'b1 || gnt !== 4'b0010) begin
            errors++;
            $display("FAIL mid_grant: got busy=%b gnt=%b, want 1 0010", busy, gnt);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, gnt, gnt_id, done, parity_ok, err_cnt} !== 17'd0) begin
            errors++;
            $display("FAIL mid_reset: got busy=%b gnt=%b id=%0d done=%b ok=%b cnt=%0d, want all 0",
                     busy, gnt, gnt_id, done, parity_ok, err_cnt);
        end
        req = 4'b0100; data_in = 32'h0000_0000;
        step();
        checks++;
        if (done !== 1'b0 || err_cnt !== 8'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_hold: got done=%b cnt=%0d busy=%b, want 0 0 0", done, err_cnt, busy);
        end
        rst = 1'b0;
        step();
        checks++;
        if (gnt !== 4'b0100 || gnt_id !== 2'd2) begin
            errors++;
            $display("FAIL post_reset_arb: got gnt=%b id=%0d, want 0100 2", gnt, gnt_id);
        end
        req = 4'b0000;
        step();
        checks++;
        if (done !== 1'b1 || parity_ok !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_done: got done=%b ok=%b, want 1 1", done, parity_ok);
        end
        step();
    endtask

    initial begin
        rst = 1'b1; req = '0; data_in = '0; parity_in = '0; odd_mode = 1'b0; clr_cnt = 1'b0;
        test_reset();
        test_basic();
        test_parity_modes();
        test_round_robin();
        test_alternate();
        test_saturation();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
